// File: rtl/uart_rx_fifo.sv
// UART receiver: oversampled frame decode feeding a show-ahead receive queue.
// Define UART_RX_FIFO_EN for a DEPTH-entry FIFO; otherwise one holding register.
module uart_rx_fifo #(
   parameter int unsigned CLK_HZ = 50_000_000,
   parameter int unsigned OVS    = 16,
   parameter int unsigned DEPTH  = 16
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       rx,
   input  logic                       eight,
   input  logic                       pen,
   input  logic                       ohel,
   input  logic [3:0]                 baud,
   input  logic                       rx_ready,
   input  logic                       clr_ovf,
   output logic                       rx_valid,
   output logic [7:0]                 rx_data,
   output logic                       rx_perr,
   output logic                       rx_ferr,
   output logic                       rx_ovf,
   output logic [$clog2(DEPTH+1)-1:0] rx_count,
   output logic                       rx_busy
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_START = 3'd1;
   localparam logic [2:0] S_DATA  = 3'd2;
   localparam logic [2:0] S_PAR   = 3'd3;
   localparam logic [2:0] S_STOP  = 3'd4;

   function automatic int unsigned div_of(input int unsigned rate);
      int unsigned d;
      d = CLK_HZ / (OVS * rate);
      return (d == 0) ? 1 : d;
   endfunction

   localparam int unsigned DIV_MAX = div_of(300);
   localparam int DW = (DIV_MAX > 1) ? $clog2(DIV_MAX) : 1;
   localparam int SW = $clog2(OVS);
   localparam int CW = $clog2(DEPTH + 1);
`ifdef UART_RX_FIFO_EN
   localparam int unsigned FD = DEPTH;
`else
   localparam int unsigned FD = 1;
`endif

   logic          rx_s1_q, rx_s1_d;
   logic          rx_s2_q, rx_s2_d;
   logic          rx_prev_q, rx_prev_d;
   logic [1:0]    flush_q, flush_d;
   logic          armed_q, armed_d;
   logic [2:0]    state_q, state_d;
   logic [DW-1:0] tick_q, tick_d;
   logic [SW-1:0] samp_q, samp_d;
   logic [2:0]    bit_q, bit_d;
   logic [7:0]    data_q, data_d;
   logic          perr_q, perr_d;
   logic          eight_q, eight_d;
   logic          pen_q, pen_d;
   logic          ohel_q, ohel_d;
   logic [3:0]    baud_q, baud_d;
   logic [CW-1:0] count_q, count_d;
   logic          ovf_q, ovf_d;

   logic [DW-1:0] div_m1;
   logic          tick;
   logic          samp_hit;
   logic          sample;
   logic          start_det;
   logic          push;
   logic [9:0]    entry;
   logic [9:0]    head;
   logic          valid;
   logic          pop;
   logic          full;
   logic          accept;
   logic          ovf_set;

   // Synchroniser, edge history and arming; the reset-loaded sync
   // values are not real line samples, so arming waits for a flush.
   always_comb begin
      rx_s1_d   = rx;
      rx_s2_d   = rx_s1_q;
      rx_prev_d = rx_s2_q;
      flush_d   = {flush_q[0], 1'b1};
      armed_d   = armed_q | (flush_q[1] & rx_s2_q);
   end

   assign start_det = (state_q == S_IDLE) & armed_q
                    & rx_prev_q & ~rx_s2_q;

   // Oversample divisor for the rate latched at start detect.
   always_comb begin
      case (baud_q)
         4'd0:    div_m1 = DW'(div_of(300) - 1);
         4'd1:    div_m1 = DW'(div_of(1200) - 1);
         4'd2:    div_m1 = DW'(div_of(2400) - 1);
         4'd3:    div_m1 = DW'(div_of(4800) - 1);
         4'd4:    div_m1 = DW'(div_of(9600) - 1);
         4'd5:    div_m1 = DW'(div_of(19200) - 1);
         4'd6:    div_m1 = DW'(div_of(38400) - 1);
         4'd7:    div_m1 = DW'(div_of(57600) - 1);
         4'd8:    div_m1 = DW'(div_of(115200) - 1);
         4'd9:    div_m1 = DW'(div_of(230400) - 1);
         4'd10:   div_m1 = DW'(div_of(460800) - 1);
         default: div_m1 = DW'(div_of(921600) - 1);
      endcase
   end

   assign tick     = (tick_q == div_m1);
   assign samp_hit = (state_q == S_START)
                   ? (samp_q == SW'(OVS / 2 - 1))
                   : (samp_q == SW'(OVS - 1));
   assign sample   = (state_q != S_IDLE) & tick & samp_hit;
   assign entry    = {~rx_s2_q, perr_q, data_q};

   // Frame FSM: half-bit start check, then one sample per bit.
   always_comb begin
      state_d = state_q;
      tick_d  = tick_q;
      samp_d  = samp_q;
      bit_d   = bit_q;
      data_d  = data_q;
      perr_d  = perr_q;
      eight_d = eight_q;
      pen_d   = pen_q;
      ohel_d  = ohel_q;
      baud_d  = baud_q;
      push    = 1'b0;
      if (start_det) begin
         state_d = S_START;
         tick_d  = '0;
         samp_d  = '0;
         bit_d   = '0;
         data_d  = '0;
         perr_d  = 1'b0;
         eight_d = eight;
         pen_d   = pen;
         ohel_d  = ohel;
         baud_d  = baud;
      end else if (state_q != S_IDLE) begin
         tick_d = tick ? '0 : tick_q + DW'(1);
         if (tick) begin
            samp_d = samp_hit ? '0 : samp_q + SW'(1);
         end
         if (sample) begin
            case (state_q)
               S_START: begin
                  state_d = rx_s2_q ? S_IDLE : S_DATA;
               end
               S_DATA: begin
                  data_d[bit_q] = rx_s2_q;
                  if (bit_q == (eight_q ? 3'd7 : 3'd6)) begin
                     bit_d   = '0;
                     state_d = pen_q ? S_PAR : S_STOP;
                  end else begin
                     bit_d = bit_q + 3'd1;
                  end
               end
               S_PAR: begin
                  perr_d  = ((^data_q) ^ rx_s2_q) != ohel_q;
                  state_d = S_STOP;
               end
               S_STOP: begin
                  push    = 1'b1;
                  state_d = S_IDLE;
               end
               default: state_d = S_IDLE;
            endcase
         end
      end
   end

   assign valid   = (count_q != '0);
   assign pop     = valid & rx_ready;
   assign full    = (count_q == CW'(FD));
   assign accept  = push & (~full | pop);
   assign ovf_set = push & full & ~pop;

   // Occupancy and sticky overflow; a new overflow beats a clear.
   always_comb begin
      count_d = count_q;
      case ({accept, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
      ovf_d = ovf_set | (ovf_q & ~clr_ovf);
   end

`ifdef UART_RX_FIFO_EN
   localparam int AW = $clog2(DEPTH);

   logic [9:0]    mem_q [DEPTH];
   logic [AW-1:0] wr_q, wr_d;
   logic [AW-1:0] rd_q, rd_d;

   // Circular pointers; DEPTH is a power of two so they wrap naturally.
   always_comb begin
      wr_d = accept ? wr_q + AW'(1) : wr_q;
      rd_d = pop ? rd_q + AW'(1) : rd_q;
      head = mem_q[rd_q];
   end

   // Entry storage needs no reset; occupancy guards the head.
   always_ff @(posedge clk) begin
      if (accept) begin
         mem_q[wr_q] <= entry;
      end
   end

   // Pointer registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_q <= '0;
         rd_q <= '0;
      end else begin
         wr_q <= wr_d;
         rd_q <= rd_d;
      end
   end
`else
   logic [9:0] hold_q, hold_d;

   // Single holding register; an overflowing frame leaves it untouched.
   always_comb begin
      hold_d = accept ? entry : hold_q;
      head   = hold_q;
   end

   // Holding register state.
   always_ff @(posedge clk) begin
      if (reset) begin
         hold_q <= '0;
      end else begin
         hold_q <= hold_d;
      end
   end
`endif

   // Receiver and queue control state.
   always_ff @(posedge clk) begin
      if (reset) begin
         rx_s1_q   <= 1'b1;
         rx_s2_q   <= 1'b1;
         rx_prev_q <= 1'b1;
         flush_q   <= '0;
         armed_q   <= 1'b0;
         state_q   <= S_IDLE;
         tick_q    <= '0;
         samp_q    <= '0;
         bit_q     <= '0;
         data_q    <= '0;
         perr_q    <= 1'b0;
         eight_q   <= 1'b1;
         pen_q     <= 1'b0;
         ohel_q    <= 1'b0;
         baud_q    <= '0;
         count_q   <= '0;
         ovf_q     <= 1'b0;
      end else begin
         rx_s1_q   <= rx_s1_d;
         rx_s2_q   <= rx_s2_d;
         rx_prev_q <= rx_prev_d;
         flush_q   <= flush_d;
         armed_q   <= armed_d;
         state_q   <= state_d;
         tick_q    <= tick_d;
         samp_q    <= samp_d;
         bit_q     <= bit_d;
         data_q    <= data_d;
         perr_q    <= perr_d;
         eight_q   <= eight_d;
         pen_q     <= pen_d;
         ohel_q    <= ohel_d;
         baud_q    <= baud_d;
         count_q   <= count_d;
         ovf_q     <= ovf_d;
      end
   end

   assign rx_valid = valid;
   assign rx_data  = valid ? head[7:0] : 8'h00;
   assign rx_perr  = valid & head[8];
   assign rx_ferr  = valid & head[9];
   assign rx_ovf   = ovf_q;
   assign rx_count = count_q;
   assign rx_busy  = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: directed frames plus randomized traffic,
// checked every cycle against a queue model of the receive path.
module tb_uart_rx_fifo;

   localparam int CLK_HZ = 50_000_000;
   localparam int OVS    = 16;
   localparam int DEPTH  = 16;
   localparam int CW     = $clog2(DEPTH + 1);
`ifdef UART_RX_FIFO_EN
   localparam int CAP = DEPTH;
`else
   localparam int CAP = 1;
`endif

   logic          clk = 1'b0;
   logic          reset;
   logic          rx;
   logic          eight;
   logic          pen;
   logic          ohel;
   logic [3:0]    baud;
   logic          rx_ready;
   logic          clr_ovf;
   logic          rx_valid;
   logic [7:0]    rx_data;
   logic          rx_perr;
   logic          rx_ferr;
   logic          rx_ovf;
   logic [CW-1:0] rx_count;
   logic          rx_busy;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   logic [9:0] mq[$];
   logic [9:0] pend[$];
   bit         movf;
   bit         pop_f;
   bit         clr_f;
   bit         busy_prev;
   int         fall_cyc;

   uart_rx_fifo #(.CLK_HZ(CLK_HZ), .OVS(OVS), .DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset), .rx(rx), .eight(eight), .pen(pen),
      .ohel(ohel), .baud(baud), .rx_ready(rx_ready),
      .clr_ovf(clr_ovf), .rx_valid(rx_valid), .rx_data(rx_data),
      .rx_perr(rx_perr), .rx_ferr(rx_ferr), .rx_ovf(rx_ovf),
      .rx_count(rx_count), .rx_busy(rx_busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: run did not finish");
      $fatal(1);
   end

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   function automatic int bit_clks(input logic [3:0] b);
      int rate;
      int d;
      case (b)
         4'd0:    rate = 300;
         4'd1:    rate = 1200;
         4'd2:    rate = 2400;
         4'd3:    rate = 4800;
         4'd4:    rate = 9600;
         4'd5:    rate = 19200;
         4'd6:    rate = 38400;
         4'd7:    rate = 57600;
         4'd8:    rate = 115200;
         4'd9:    rate = 230400;
         4'd10:   rate = 460800;
         default: rate = 921600;
      endcase
      d = CLK_HZ / (OVS * rate);
      if (d < 1) d = 1;
      return OVS * d;
   endfunction

   // Queue model: a frame lands when busy drops, pops one cycle
   // after valid&ready, clears one cycle after clr_ovf.
   always @(negedge clk) begin
      logic [9:0]  e;
      logic [9:0]  hd;
      logic [31:0] ev;
      logic [31:0] av;
      bit          v;
      if (reset) begin
         mq.delete();
         pend.delete();
         movf      = 0;
         pop_f     = 0;
         clr_f     = 0;
         busy_prev = 0;
      end else begin
         if (pop_f) void'(mq.pop_front());
         if (clr_f) movf = 0;
         if (busy_prev && !rx_busy) begin
            fall_cyc = cyc;
            if (pend.size() > 0) begin
               e = pend.pop_front();
               if (mq.size() < CAP) mq.push_back(e);
               else movf = 1;
            end
         end
         busy_prev = rx_busy;
         v  = mq.size() > 0;
         hd = v ? mq[0] : 10'd0;
         ev = {v, CW'(mq.size()), movf, hd[7:0], hd[8], hd[9]};
         av = {rx_valid, rx_count, rx_ovf, rx_data, rx_perr, rx_ferr};
         chk("cycle {valid,count,ovf,data,perr,ferr}", av, ev);
         pop_f = v && rx_ready;
         clr_f = clr_ovf;
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic pop1();
      rx_ready = 1'b1;
      tick(1);
      rx_ready = 1'b0;
      tick(1);
   endtask

   task automatic send(input logic [7:0] d, input bit e8, input bit pe,
                       input bit od, input bit pbit, input bit sbit,
                       input logic [3:0] bd, input bit scr);
      int         b;
      logic [7:0] dd;
      eight = e8;
      pen   = pe;
      ohel  = od;
      baud  = bd;
      b     = bit_clks(bd);
      dd    = e8 ? d : {1'b0, d[6:0]};
      pend.push_back({~sbit, pe ? ((^dd ^ pbit) != od) : 1'b0, dd});
      rx = 1'b0;
      if (scr) begin
         tick(6);
         eight = 1'($urandom);
         pen   = 1'($urandom);
         ohel  = 1'($urandom);
         baud  = 4'($urandom);
         tick(b - 6);
      end else begin
         tick(b);
      end
      for (int i = 0; i < (e8 ? 8 : 7); i++) begin
         rx = d[i];
         tick(b);
      end
      if (pe) begin
         rx = pbit;
         tick(b);
      end
      rx = sbit;
      tick(b);
   endtask

   initial begin
      int         c0;
      int         lat;
      bit         saw;
      bit         rnd_on;
      logic [7:0] first;
      reset    = 1'b1;
      rx       = 1'b0;
      eight    = 1'b1;
      pen      = 1'b0;
      ohel     = 1'b0;
      baud     = 4'd11;
      rx_ready = 1'b0;
      clr_ovf  = 1'b0;
      tick(5);
      chk("reset rx_valid", rx_valid, 0);
      chk("reset rx_data", rx_data, 0);
      chk("reset rx_perr", rx_perr, 0);
      chk("reset rx_ferr", rx_ferr, 0);
      chk("reset rx_ovf", rx_ovf, 0);
      chk("reset rx_count", rx_count, 0);
      chk("reset rx_busy", rx_busy, 0);
      reset = 1'b0;
      tick(200);
      chk("low after reset busy", rx_busy, 0);
      chk("low after reset count", rx_count, 0);
      rx = 1'b1;
      tick(20);

      c0 = cyc;
      send(8'hA5, 1, 0, 0, 0, 1, 4'd11, 0);
      tick(5);
      lat = fall_cyc - c0;
      chk("busy falls inside stop bit", (lat >= 432 && lat <= 480), 1);
      chk("A5 valid", rx_valid, 1);
      chk("A5 data", rx_data, 8'hA5);
      chk("A5 perr", rx_perr, 0);
      chk("A5 ferr", rx_ferr, 0);
      chk("A5 count", rx_count, 1);
      pop1();
      if (lat < 2 || lat > 2000) lat = 459;

      send(8'h55, 0, 1, 0, 0, 1, 4'd11, 0);
      tick(5);
      chk("7E p0 data", rx_data, 8'h55);
      chk("7E p0 perr", rx_perr, 0);
      pop1();
      send(8'h55, 0, 1, 0, 1, 1, 4'd11, 0);
      tick(5);
      chk("7E p1 perr", rx_perr, 1);
      pop1();
      send(8'h55, 0, 1, 1, 1, 1, 4'd11, 0);
      tick(5);
      chk("7O p1 perr", rx_perr, 0);
      pop1();

      send(8'h81, 1, 0, 0, 0, 0, 4'd11, 0);
      tick(20 * 48);
      chk("break count", rx_count, 1);
      chk("break ferr", rx_ferr, 1);
      rx = 1'b1;
      tick(48);
      pop1();
      send(8'h3C, 1, 0, 0, 0, 1, 4'd11, 0);
      tick(5);
      chk("3C data", rx_data, 8'h3C);
      chk("3C flags", {rx_perr, rx_ferr}, 0);
      chk("3C count", rx_count, 1);
      pop1();

      saw = 0;
      fork
         begin
            rx = 1'b0;
            tick(16);
            rx = 1'b1;
         end
         begin
            repeat (60) begin
               @(negedge clk);
               if (rx_busy) saw = 1;
            end
         end
      join
      tick(100);
      chk("glitch busy seen", saw, 1);
      chk("glitch busy low", rx_busy, 0);
      chk("glitch count", rx_count, 0);

      first = 8'($urandom);
      for (int k = 0; k < CAP + 1; k++) begin
         send((k == 0) ? first : 8'($urandom), 1, 0, 0, 0, 1,
              4'd11, 0);
         tick(10);
      end
      chk("fill count", rx_count, CAP);
      chk("fill ovf", rx_ovf, 1);
      chk("fill head", rx_data, first);
      clr_ovf = 1'b1;
      tick(1);
      clr_ovf = 1'b0;
      tick(1);
      chk("clr_ovf", rx_ovf, 0);

      c0 = cyc;
      fork
         send(8'($urandom), 1, 0, 0, 0, 1, 4'd11, 0);
         begin
            while (cyc < c0 + lat - 1) tick(1);
            rx_ready = 1'b1;
            tick(1);
            rx_ready = 1'b0;
         end
      join
      tick(10);
      chk("full push+pop count", rx_count, CAP);
      chk("full push+pop ovf", rx_ovf, 0);
      rx_ready = 1'b1;
      for (int k = 0; k < 200 && rx_count != 0; k++) tick(1);
      rx_ready = 1'b0;
      tick(2);
      chk("drained", rx_count, 0);

      rnd_on = 1;
      fork
         begin
            for (int k = 0; k < 24; k++) begin
               send(8'($urandom), 1'($urandom), 1'($urandom),
                    1'($urandom), 1'($urandom),
                    $urandom_range(0, 5) != 0,
                    4'($urandom_range(10, 15)), 1);
               rx = 1'b1;
               tick($urandom_range(4, 60));
            end
            rnd_on = 0;
         end
         begin
            while (rnd_on) begin
               rx_ready = $urandom_range(0, 3) == 0;
               clr_ovf  = $urandom_range(0, 40) == 0;
               tick(1);
            end
            rx_ready = 1'b0;
            clr_ovf  = 1'b0;
         end
      join
      tick(2);
      rx_ready = 1'b1;
      for (int k = 0; k < 200 && rx_count != 0; k++) tick(1);
      rx_ready = 1'b0;
      tick(2);
      chk("random drained", rx_count, 0);

      rx = 1'b0;
      tick(100);
      chk("mid-frame busy", rx_busy, 1);
      reset = 1'b1;
      rx    = 1'b1;
      tick(3);
      reset = 1'b0;
      tick(10);
      chk("mid-frame reset busy", rx_busy, 0);
      chk("mid-frame reset count", rx_count, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
